// File: rtl/rr_onehot_arbiter_if.sv
// rtl/rr_onehot_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
//
// Purpose: groups the request vector and the registered grant outputs.
// Signals:
//   req_i        NUM_REQ  level request per requester, held until served
//   gnt_o        NUM_REQ  registered grant, all-zero or one-hot
//   gnt_idx_o    IDX_W    binary index of the granted requester
//   gnt_valid_o  1        high when gnt_o is non-zero
// Modports:
//   master  requester side (drives req_i, observes the grant)
//   slave   arbiter side (observes req_i, drives the grant)
`timescale 1ns/1ps
interface rr_onehot_arbiter_if #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic               gnt_valid_o;

  modport master (
    output req_i,
    input  gnt_o,
    input  gnt_idx_o,
    input  gnt_valid_o
  );

  modport slave (
    input  req_i,
    output gnt_o,
    output gnt_idx_o,
    output gnt_valid_o
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - round-robin arbiter with registered one-hot grant and hold limit
//
// Purpose: shares one resource between NUM_REQ requesters. The grant is a
// registered one-hot vector plus its binary index (gnt_o == 1 << gnt_idx_o
// whenever gnt_valid_o is high). A grant is kept until the owner drops its
// request or MAX_HOLD consecutive cycles have elapsed (MAX_HOLD = 0: no limit).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    rr_onehot_arbiter_if.slave: req_i in; gnt_o, gnt_idx_o, gnt_valid_o out
`timescale 1ns/1ps
module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_onehot_arbiter_if.slave    bus
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   ptr_q, ptr_n;
  logic [HOLD_W-1:0]  hold_q, hold_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [IDX_W-1:0]   idx_q, idx_n;

  logic [IDX_W-1:0]   search_start;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   win;
  logic               found;
  logic               release_gnt;

  // While granting, a release moves the pointer to owner+1 and the search
  // must already use that value this cycle, so it is computed directly here
  // rather than waiting for ptr_q to update.
  assign search_start = (state_q == S_GRANT) ? (idx_q + IDX_W'(1)) : ptr_q;

  // Rotating priority scan: first set request at or above search_start,
  // wrapping through NUM_REQ-1 -> 0. Power-of-two NUM_REQ makes the
  // IDX_W-bit add wrap on its own.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = search_start + IDX_W'(i);
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    release_gnt = !bus.req_i[idx_q];
    if (MAX_HOLD != 0) begin
      if (hold_q == HOLD_W'(MAX_HOLD)) begin
        release_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    hold_n  = hold_q;
    gnt_n   = gnt_q;
    idx_n   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_n   = NUM_REQ'(1) << win;
          idx_n   = win;
          hold_n  = HOLD_W'(1);
          state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        if (release_gnt) begin
          ptr_n = search_start;
          if (found) begin
            // Back-to-back handover; on timeout the old owner can win
            // again only if nobody else is requesting.
            gnt_n  = NUM_REQ'(1) << win;
            idx_n  = win;
            hold_n = HOLD_W'(1);
          end else begin
            // Index is left at the last owner so the select lines of the
            // downstream datapath do not toggle while idle.
            gnt_n   = '0;
            hold_n  = '0;
            state_n = S_IDLE;
          end
        end else if (MAX_HOLD != 0) begin
          if (hold_q != HOLD_W'(MAX_HOLD)) begin
            hold_n = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
      gnt_q   <= gnt_n;
      idx_q   <= idx_n;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = (state_q == S_GRANT);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - scoreboard bench for rr_onehot_arbiter (NUM_REQ=16, MAX_HOLD=4)
`timescale 1ns/1ps
module tb_rr_onehot_arbiter;

  localparam int NUM_REQ  = 16;
  localparam int IDX_W    = 4;
  localparam int MAX_HOLD = 4;
  localparam int STARVE_BOUND = (NUM_REQ - 1) * MAX_HOLD + 1;

  typedef struct {
    logic       v;
    logic [3:0] idx;
    string      name;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t exp_q[$];

  rr_onehot_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

  rr_onehot_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, queue depth=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: invariants every cycle, and scoreboard pop whenever an
  // expected grant is queued for this edge.
  always @(posedge clk) begin
    exp_t e;
    logic [15:0] exp_gnt;
    #1;
    total++;
    if ((bus.gnt_valid_o !== (|bus.gnt_o)) ||
        ($countones(bus.gnt_o) > 1) ||
        (bus.gnt_valid_o && (bus.gnt_o !== (16'h1 << bus.gnt_idx_o)))) begin
      bad++;
      $display("FAIL invariant @%0t: gnt=%h idx=%0d valid=%b, required one-hot gnt==1<<idx and valid==|gnt",
               $time, bus.gnt_o, bus.gnt_idx_o, bus.gnt_valid_o);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_gnt = e.v ? (16'h1 << e.idx) : 16'h0;
      total++;
      if ((bus.gnt_o !== exp_gnt) || (bus.gnt_valid_o !== e.v) || (bus.gnt_idx_o !== e.idx)) begin
        bad++;
        $display("FAIL %s @%0t: gnt=%h valid=%b idx=%0d, required gnt=%h valid=%b idx=%0d",
                 e.name, $time, bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o, exp_gnt, e.v, e.idx);
      end
    end
  end

  // Apply req at a falling edge and queue the grant expected after the next rising edge.
  task automatic step(input logic [15:0] req, input logic v, input logic [3:0] idx, input string name);
    exp_t e;
    @(negedge clk);
    bus.req_i = req;
    e.v = v;
    e.idx = idx;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_i = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    int waitc[16];
    int maxw;
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.req_i = '0;
    #2;
    total++;
    if (bus.gnt_o !== 16'h0 || bus.gnt_valid_o !== 1'b0 || bus.gnt_idx_o !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: gnt=%h valid=%b idx=%0d, required 0/0/0",
               bus.gnt_o, bus.gnt_valid_o, bus.gnt_idx_o);
    end
    do_reset();

    // 1: asynchronous reset while idx 5 is granted
    step(16'h0020, 1'b1, 4'd5, "t1_grant5");
    step(16'h0020, 1'b1, 4'd5, "t1_hold5");
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.gnt_o !== 16'h0 || bus.gnt_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL t1_async_reset: gnt=%h valid=%b, required 0000/0", bus.gnt_o, bus.gnt_valid_o);
    end
    bus.req_i = '0;
    @(negedge clk);
    reset = 1'b0;

    // 2: single requester keeps the grant across timeouts
    do_reset();
    for (int k = 0; k < 12; k++) step(16'h0001, 1'b1, 4'd0, "t2_single_hold");

    // 3: owner 0 drops after 2 cycles, 15 takes over
    do_reset();
    step(16'h8001, 1'b1, 4'd0, "t3_first");
    step(16'h8001, 1'b1, 4'd0, "t3_second");
    step(16'h8000, 1'b1, 4'd15, "t3_handover15");
    step(16'h8000, 1'b1, 4'd15, "t3_hold15");

    // 4: all requesting, 4-cycle slots in index order with wrap
    do_reset();
    for (int k = 0; k < 68; k++) step(16'hFFFF, 1'b1, 4'((k / 4) % 16), "t4_full_rotation");

    // 5: owner 14 times out with 0 pending, ptr wraps to 15 and 0 wins
    do_reset();
    step(16'h4000, 1'b1, 4'd14, "t5_grant14");
    for (int k = 0; k < 3; k++) step(16'h4001, 1'b1, 4'd14, "t5_hold14");
    step(16'h4001, 1'b1, 4'd0, "t5_wrap_to0");
    step(16'h0000, 1'b0, 4'd0, "t5_idle");

    // 6: owner 3 drops alone -> idle, idx kept; then 0x0009 scanned from ptr=4
    do_reset();
    step(16'h0008, 1'b1, 4'd3, "t6_grant3");
    step(16'h0000, 1'b0, 4'd3, "t6_idle_keep_idx");
    step(16'h0000, 1'b0, 4'd3, "t6_idle_stay");
    step(16'h0009, 1'b1, 4'd0, "t6_scan_from4");
    step(16'h0000, 1'b0, 4'd0, "t6_idle_again");

    // Random held requests: invariants by the monitor, starvation bound here
    do_reset();
    r = '0;
    maxw = 0;
    for (int i = 0; i < 16; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        if (r[i]) begin
          if (bus.gnt_o[i]) begin
            waitc[i] = 0;
            if ($urandom_range(3) == 0) r[i] = 1'b0;
          end else begin
            waitc[i]++;
            if (waitc[i] > maxw) maxw = waitc[i];
          end
        end else if ($urandom_range(7) == 0) begin
          r[i] = 1'b1;
          waitc[i] = 0;
        end
      end
      bus.req_i = r;
    end
    total++;
    if (maxw > STARVE_BOUND) begin
      bad++;
      $display("FAIL starvation: longest wait=%0d cycles, required <= %0d", maxw, STARVE_BOUND);
    end

    @(negedge clk);
    bus.req_i = '0;
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
